save_bank: RTL

SAVE_BANK -- requirements
Module: save_bank

---
 rtl/save_bank.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/save_bank.sv
// Frame capture bank: collects DEPTH samples by auto-index or by address,
// then holds the complete frame on y_flat until the consumer acknowledges it.
module save_bank #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [IDX_W-1:0]       sel,
  input  logic                   frame_ack,
  output logic                   in_ready,
  output logic [WIDTH*DEPTH-1:0] y_flat,
  output logic                   frame_valid,
  output logic [IDX_W-1:0]       wr_idx,
  output logic                   sel_err
);

  localparam logic [0:0] StFill = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_d;
  logic [WIDTH-1:0] r_slots [DEPTH];
  logic [DEPTH-1:0] r_mask;
  logic [DEPTH-1:0] w_mask_d;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] w_wr_idx_d;
  logic             r_fmode;
  logic             w_fmode_d;
  logic             r_fmode_vld;
  logic             w_fmode_vld_d;
  logic             r_sel_err;
  logic             w_sel_err_d;

  logic             w_accept;
  logic             w_mode_eff;
  logic             w_sel_oob;
  logic [DEPTH-1:0] w_sel_hot;
  logic [DEPTH-1:0] w_idx_hot;
  logic [DEPTH-1:0] w_mask_upd;
  logic [DEPTH-1:0] w_slot_we;

  assign in_ready    = (r_state == StFill);
  assign frame_valid = (r_state == StHold);
  assign wr_idx      = r_wr_idx;
  assign sel_err     = r_sel_err;

  assign w_accept = in_valid & in_ready;
  // The first accept of a frame samples mode; later accepts use the latched copy.
  assign w_mode_eff = r_fmode_vld ? r_fmode : mode;
  assign w_sel_oob  = (32'(sel) >= DEPTH);
  assign w_mask_upd = r_mask | w_sel_hot;

  always_comb begin
    w_sel_hot = '0;
    w_idx_hot = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_sel_hot[k] = (32'(sel) == k);
      w_idx_hot[k] = (32'(r_wr_idx) == k);
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_mask_d      = r_mask;
    w_wr_idx_d    = r_wr_idx;
    w_fmode_d     = r_fmode;
    w_fmode_vld_d = r_fmode_vld;
    w_sel_err_d   = 1'b0;
    w_slot_we     = '0;

    case (r_state)
      StFill: begin
        if (w_accept) begin
          w_fmode_vld_d = 1'b1;
          w_fmode_d     = w_mode_eff;
          if (!w_mode_eff) begin
            w_slot_we = w_idx_hot;
            if (r_wr_idx == LastIdx) begin
              w_wr_idx_d = '0;
              w_state_d  = StHold;
            end else begin
              w_wr_idx_d = r_wr_idx + IDX_W'(1);
            end
          end else if (w_sel_oob) begin
            w_sel_err_d = 1'b1;
          end else begin
            w_slot_we = w_sel_hot;
            w_mask_d  = w_mask_upd;
            if (&w_mask_upd) begin
              w_state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (frame_ack) begin
          w_state_d     = StFill;
          w_mask_d      = '0;
          w_wr_idx_d    = '0;
          w_fmode_d     = 1'b0;
          w_fmode_vld_d = 1'b0;
        end
      end
      default: w_state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StFill;
      r_mask      <= '0;
      r_wr_idx    <= '0;
      r_fmode     <= 1'b0;
      r_fmode_vld <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_mask      <= w_mask_d;
      r_wr_idx    <= w_wr_idx_d;
      r_fmode     <= w_fmode_d;
      r_fmode_vld <= w_fmode_vld_d;
      r_sel_err   <= w_sel_err_d;
    end
  end

  // Slot data survives frame_ack; only reset or a new write changes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_slots[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_slot_we[k]) begin
          r_slots[k] <= in_data;
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign y_flat[g*WIDTH +: WIDTH] = r_slots[g];
  end

endmodule
